mem_arbiter: RTL

Two-master arbiter sharing the single data port of the main memory manager between the core's execute-stage load/store path (master C) and a debug/program-loader master (master D). Round-robin grant with optional bus locking for multi-beat sequences, bounded by a lock limit so neither master starves. Sits between both masters and the memory manager data port; the instruction port is not arbitrated.

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin data-port arbiter with bounded bus locking
module mem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [WIDTH-1:0] c_addr,
  input  logic [WIDTH-1:0] c_wdata,
  input  logic [2:0]       c_bytes,
  input  logic             c_unsigned,
  input  logic             c_lock,
  output logic             c_gnt,
  output logic             c_rvalid,
  output logic [WIDTH-1:0] c_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [2:0]       d_bytes,
  input  logic             d_unsigned,
  input  logic             d_lock,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic [WIDTH-1:0] m_addr,
  output logic             m_re,
  output logic             m_we,
  output logic [2:0]       m_bytes,
  output logic             m_unsigned,
  output logic [WIDTH-1:0] m_wdata,
  input  logic [WIDTH-1:0] m_rdata
);

  localparam int LW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, OWN_C, OWN_D} state_t;

  state_t          state;
  logic            last;   // 0 = C won most recently, 1 = D
  logic [LW-1:0]   lcnt;   // transfers already taken in the current locked burst
  logic            rpend;
  logic            rsel;   // 0 = C, 1 = D

  logic            acc;
  logic            g_we;
  logic            g_lock;
  logic            lock_more;

  // Grant: lock owner exclusive, otherwise round-robin on ties; nothing while in reset
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      case (state)
        OWN_C:   c_gnt = c_req;
        OWN_D:   d_gnt = d_req;
        default: begin
          if (c_req && d_req) begin
            c_gnt = last;
            d_gnt = !last;
          end else begin
            c_gnt = c_req;
            d_gnt = d_req;
          end
        end
      endcase
    end
  end

  // Memory-side mux follows the granted master; C's values when nobody is granted
  always_comb begin
    acc        = c_gnt | d_gnt;
    g_we       = d_gnt ? d_we       : c_we;
    g_lock     = d_gnt ? d_lock     : c_lock;
    m_addr     = d_gnt ? d_addr     : c_addr;
    m_wdata    = d_gnt ? d_wdata    : c_wdata;
    m_bytes    = d_gnt ? d_bytes    : c_bytes;
    m_unsigned = d_gnt ? d_unsigned : c_unsigned;
    m_re       = acc && !g_we;
    m_we       = acc && g_we;
    // Releasing on the MAX_LOCK-th transfer caps a burst at exactly MAX_LOCK grants
    lock_more  = (lcnt < LW'(MAX_LOCK - 1));
  end

  assign c_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign c_rvalid = rpend && !rsel;
  assign d_rvalid = rpend && rsel;

  // Ownership FSM, round-robin history and read-return tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
      lcnt  <= '0;
      rpend <= 1'b0;
      rsel  <= 1'b0;
    end else begin
      rpend <= acc && !g_we;
      rsel  <= d_gnt;
      if (acc) begin
        last <= d_gnt;
      end
      case (state)
        IDLE: begin
          if (acc && g_lock && (MAX_LOCK > 1)) begin
            state <= d_gnt ? OWN_D : OWN_C;
            lcnt  <= LW'(1);
          end
        end
        default: begin
          if (acc && g_lock && lock_more) begin
            lcnt <= lcnt + LW'(1);
          end else begin
            state <= IDLE;
            lcnt  <= '0;
          end
        end
      endcase
    end
  end

endmodule
